// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control / HI-LO sequencer: ALUOp classes,
// OpSel codes, funct codes, mul/div op encoding and the sequencer state type.
package alu_ctrl_pkg;

    localparam logic [5:0] ALUOP_ZER_R = 6'h00;
    localparam logic [5:0] ALUOP_SUB_R = 6'h01;
    localparam logic [5:0] ALUOP_SLL_R = 6'h02;
    localparam logic [5:0] ALUOP_ADD_R = 6'h04;
    localparam logic [5:0] ALUOP_AND_R = 6'h08;
    localparam logic [5:0] ALUOP_OR_R  = 6'h10;
    localparam logic [5:0] ALUOP_R_TYP = 6'h20;

    localparam logic [5:0] OPSEL_AND = 6'h24;
    localparam logic [5:0] OPSEL_OR  = 6'h25;
    localparam logic [5:0] OPSEL_ADD = 6'h20;
    localparam logic [5:0] OPSEL_SUB = 6'h22;
    localparam logic [5:0] OPSEL_SLL = 6'h00;

    localparam logic [5:0] FUNCT_JR    = 6'h08;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // 0x18..0x1B share funct[5:2]=0110, 0x10..0x13 share 0100
    function automatic logic is_md_funct(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction

    function automatic logic is_hilo_funct(input logic [5:0] f);
        return f[5:2] == 4'b0100;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct decode: OpSel, shift amount and the mul/div and
// HI/LO instruction class flags used by the sequencer.
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic [5:0]         i_aluop,
    input  logic [5:0]         i_funct,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic [5:0]         o_opsel,
    output logic [SHAMT_W-1:0] o_shamt,
    output logic               o_md_class,
    output logic               o_hilo_class
);

    localparam logic [SHAMT_W-1:0] LUI_SHAMT = SHAMT_W'(DATA_W / 2);

    logic w_r_typ;

    assign w_r_typ = (i_aluop == ALUOP_R_TYP);

    // NOTE: assigning o_opsel before the case keeps every path driven, so no latch is inferred.
    always_comb begin
        o_opsel = OPSEL_SLL;
        case (i_aluop)
            ALUOP_ZER_R: o_opsel = OPSEL_SLL;
            ALUOP_ADD_R: o_opsel = OPSEL_ADD;
            ALUOP_SUB_R: o_opsel = OPSEL_SUB;
            ALUOP_SLL_R: o_opsel = OPSEL_SLL;
            ALUOP_OR_R:  o_opsel = OPSEL_OR;
            ALUOP_AND_R: o_opsel = OPSEL_AND;
            ALUOP_R_TYP: o_opsel = (i_funct == FUNCT_JR) ? OPSEL_AND : i_funct;
            default:     o_opsel = OPSEL_SLL;
        endcase
    end

    assign o_shamt      = (i_aluop == ALUOP_SLL_R) ? LUI_SHAMT : i_shamt;
    assign o_md_class   = w_r_typ & is_md_funct(i_funct);
    assign o_hilo_class = w_r_typ & is_hilo_funct(i_funct);

endmodule

// File: rtl/alu_ctrl_md_seq.sv
// ALU control plus HI/LO sequencer for an iterative mul/div unit.
// Optional macro HILO_FWD_EN: MFHI/MFLO forward the unit result in DONE.
module alu_ctrl_md_seq
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SHAMT_W    = $clog2(DATA_W),
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_i,
    input  logic               flush,
    input  logic [5:0]         ALUOp,
    input  logic [5:0]         funct,
    input  logic [SHAMT_W-1:0] I_shamt,
    output logic [5:0]         OpSel,
    output logic [SHAMT_W-1:0] shamt,
    output logic               stall,
    output logic               md_start,
    output logic [1:0]         md_op,
    output logic               hilo_we,
    output logic               hilo_fwd
);

    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    logic             w_md_class;
    logic             w_hilo_class;
    logic             w_busy;
    logic             w_mf_fwd;

    md_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_md_start;
    logic [1:0]       r_md_op;
    logic             r_hilo_we;

    alu_op_decode #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_decode (
        .i_aluop      (ALUOp),
        .i_funct      (funct),
        .i_shamt      (I_shamt),
        .o_opsel      (OpSel),
        .o_shamt      (shamt),
        .o_md_class   (w_md_class),
        .o_hilo_class (w_hilo_class)
    );

    assign w_busy = (r_state != ST_IDLE);

`ifdef HILO_FWD_EN
    // MFHI/MFLO have funct[0]=0; MTHI/MTLO still wait for the write
    assign w_mf_fwd = valid_i & (r_state == ST_DONE) & w_hilo_class & ~funct[0];
`else
    assign w_mf_fwd = 1'b0;
`endif

    assign stall    = valid_i & w_busy & (w_md_class | (w_hilo_class & ~w_mf_fwd));
    assign hilo_fwd = w_mf_fwd;
    assign md_start = r_md_start;
    assign md_op    = r_md_op;
    // A flush or reset landing on the DONE cycle must not commit HI/LO
    assign hilo_we  = r_hilo_we & ~flush & ~reset;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_md_start <= 1'b0;
            r_md_op    <= MD_MULT;
            r_hilo_we  <= 1'b0;
        end else if (flush) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_md_start <= 1'b0;
            r_hilo_we  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_md_start <= 1'b0;
                    r_hilo_we  <= 1'b0;
                    if (valid_i && w_md_class) begin
                        r_state    <= ST_BUSY;
                        r_md_start <= 1'b1;
                        r_md_op    <= funct[1:0];
                        r_cnt      <= funct[1] ? DIV_LOAD : MUL_LOAD;
                    end
                end
                ST_BUSY: begin
                    r_md_start <= 1'b0;
                    if (r_cnt == '0) begin
                        r_state   <= ST_DONE;
                        r_hilo_we <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    r_hilo_we <= 1'b0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_md_start <= 1'b0;
                    r_hilo_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_md_seq.sv
// Directed bench for alu_ctrl_md_seq: decode sweep, mul/div sequencing,
// stalls, flush/reset aborts and a single-cycle multiply instance.
module tb_alu_ctrl_md_seq;
    import alu_ctrl_pkg::*;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    logic               clk = 1'b0;
    logic               reset, valid_i, flush;
    logic [5:0]         ALUOp, funct;
    logic [SHAMT_W-1:0] I_shamt;
    logic [5:0]         OpSel;
    logic [SHAMT_W-1:0] shamt;
    logic               stall, md_start, hilo_we, hilo_fwd;
    logic [1:0]         md_op;

    logic               d1_valid, d1_flush;
    logic [5:0]         d1_aluop, d1_funct;
    logic [SHAMT_W-1:0] d1_ishamt;
    logic [5:0]         d1_opsel;
    logic [SHAMT_W-1:0] d1_shamt;
    logic               d1_stall, d1_md_start, d1_hilo_we, d1_hilo_fwd;
    logic [1:0]         d1_md_op;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_ctrl_md_seq #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W), .MUL_CYCLES(4), .DIV_CYCLES(32)) u_dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .flush(flush),
        .ALUOp(ALUOp), .funct(funct), .I_shamt(I_shamt),
        .OpSel(OpSel), .shamt(shamt), .stall(stall), .md_start(md_start),
        .md_op(md_op), .hilo_we(hilo_we), .hilo_fwd(hilo_fwd)
    );

    alu_ctrl_md_seq #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W), .MUL_CYCLES(1), .DIV_CYCLES(2)) u_dut1 (
        .clk(clk), .reset(reset), .valid_i(d1_valid), .flush(d1_flush),
        .ALUOp(d1_aluop), .funct(d1_funct), .I_shamt(d1_ishamt),
        .OpSel(d1_opsel), .shamt(d1_shamt), .stall(d1_stall), .md_start(d1_md_start),
        .md_op(d1_md_op), .hilo_we(d1_hilo_we), .hilo_fwd(d1_hilo_fwd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] f);
        valid_i = v;
        ALUOp   = op;
        funct   = f;
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; valid_i = 1'b0;
        ALUOp = '0; funct = '0; I_shamt = '0;
        d1_valid = 1'b0; d1_flush = 1'b0; d1_aluop = ALUOP_R_TYP; d1_funct = '0; d1_ishamt = '0;
        tick();
        tick();
        reset = 1'b0;

        // reset state
        drive(1'b1, ALUOP_R_TYP, FUNCT_MFLO);
        check("rst_stall", stall, 0);
        check("rst_md_start", md_start, 0);
        check("rst_md_op", md_op, 0);
        check("rst_hilo_we", hilo_we, 0);
        check("rst_hilo_fwd", hilo_fwd, 0);

        // decode sweep
        drive(1'b0, ALUOP_R_TYP, FUNCT_JR);  check("dec_jr", OpSel, 6'h24);
        drive(1'b0, ALUOP_R_TYP, 6'h2A);     check("dec_slt", OpSel, 6'h2A);
        I_shamt = 5'd3;
        drive(1'b0, ALUOP_SLL_R, 6'h00);     check("dec_sll_op", OpSel, 6'h00);
        check("dec_lui_shamt", shamt, 16);
        drive(1'b0, ALUOP_ZER_R, 6'h2A);     check("dec_zer_shamt", shamt, 3);
        check("dec_zer_op", OpSel, 6'h00);
        drive(1'b0, ALUOP_ADD_R, 6'h00);     check("dec_add", OpSel, 6'h20);
        drive(1'b0, ALUOP_SUB_R, 6'h00);     check("dec_sub", OpSel, 6'h22);
        drive(1'b0, ALUOP_OR_R, 6'h00);      check("dec_or", OpSel, 6'h25);
        drive(1'b0, ALUOP_AND_R, 6'h00);     check("dec_and", OpSel, 6'h24);
        drive(1'b0, 6'h3F, 6'h2A);           check("dec_undef", OpSel, 6'h00);

        // MULT at t
        drive(1'b1, ALUOP_R_TYP, FUNCT_MULT);
        check("mult_issue_nostall", stall, 0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, ALUOP_R_TYP, FUNCT_MTLO);
            check("mult_busy_stall", stall, 1);
            check("mult_md_start", md_start, (k == 1) ? 1 : 0);
            check("mult_busy_we", hilo_we, 0);
            if (k == 1) check("mult_md_op", md_op, MD_MULT);
            drive(1'b1, ALUOP_ADD_R, 6'h00);
            check("add_nostall", stall, 0);
            tick();
        end
        drive(1'b1, ALUOP_R_TYP, FUNCT_MTHI);
        check("mult_done_stall", stall, 1);
        check("mult_done_we", hilo_we, 1);
        check("mult_done_start", md_start, 0);
        tick();
        drive(1'b1, ALUOP_R_TYP, FUNCT_MFLO);
        check("mult_idle_stall", stall, 0);
        check("mult_idle_we", hilo_we, 0);
        drive(1'b0, ALUOP_ZER_R, 6'h00);

        // DIVU at t, MFLO from t+2
        drive(1'b1, ALUOP_R_TYP, FUNCT_DIVU);
        tick();
        drive(1'b0, ALUOP_ZER_R, 6'h00);
        check("divu_start", md_start, 1);
        check("divu_op", md_op, MD_DIVU);
        tick();
        for (int k = 2; k <= 33; k++) begin
            drive(1'b1, ALUOP_R_TYP, FUNCT_MFLO);
`ifdef HILO_FWD_EN
            check("divu_mflo_stall", stall, (k == 33) ? 0 : 1);
            if (k == 33) check("divu_fwd", hilo_fwd, 1);
`else
            check("divu_mflo_stall", stall, 1);
            if (k == 33) check("divu_fwd", hilo_fwd, 0);
`endif
            check("divu_we", hilo_we, (k == 33) ? 1 : 0);
            tick();
        end
        check("divu_end_stall", stall, 0);
        check("divu_end_fwd", hilo_fwd, 0);
        check("divu_end_we", hilo_we, 0);
        drive(1'b0, ALUOP_ZER_R, 6'h00);

        // MULT then DIV back to back
        drive(1'b1, ALUOP_R_TYP, FUNCT_MULT);
        tick();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, ALUOP_R_TYP, FUNCT_DIV);
            check("b2b_div_stall", stall, 1);
            tick();
        end
        drive(1'b1, ALUOP_R_TYP, FUNCT_DIV);
        check("b2b_div_issue", stall, 0);
        tick();
        drive(1'b0, ALUOP_ZER_R, 6'h00);
        check("b2b_div_start", md_start, 1);
        check("b2b_div_op", md_op, MD_DIV);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b1, ALUOP_R_TYP, FUNCT_MFLO);
        check("b2b_flush_stall", stall, 0);
        check("b2b_flush_we", hilo_we, 0);
        drive(1'b0, ALUOP_ZER_R, 6'h00);

        // flush at t+3 during MULT
        drive(1'b1, ALUOP_R_TYP, FUNCT_MULT);
        tick();
        drive(1'b0, ALUOP_ZER_R, 6'h00);
        tick();
        tick();
        flush = 1'b1;
        drive(1'b1, ALUOP_R_TYP, FUNCT_MFLO);
        check("flush_t3_stall", stall, 1);
        tick();
        flush = 1'b0;
        #1;
        check("flush_t4_stall", stall, 0);
        drive(1'b0, ALUOP_ZER_R, 6'h00);
        for (int k = 0; k < 4; k++) begin
            check("flush_no_we", hilo_we, 0);
            tick();
        end

        // reset at t+3 during MULT
        drive(1'b1, ALUOP_R_TYP, FUNCT_MULT);
        tick();
        drive(1'b0, ALUOP_ZER_R, 6'h00);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, ALUOP_R_TYP, FUNCT_MFLO);
        check("rstmid_stall", stall, 0);
        drive(1'b0, ALUOP_ZER_R, 6'h00);
        for (int k = 0; k < 4; k++) begin
            check("rstmid_no_we", hilo_we, 0);
            tick();
        end

        // flush coinciding with DONE
        drive(1'b1, ALUOP_R_TYP, FUNCT_MULT);
        tick();
        drive(1'b0, ALUOP_ZER_R, 6'h00);
        for (int k = 0; k < 4; k++) tick();
        check("done_we_before_flush", hilo_we, 1);
        flush = 1'b1;
        #1;
        check("done_flush_we", hilo_we, 0);
        tick();
        flush = 1'b0;
        #1;
        check("done_flush_after", hilo_we, 0);

        // flush in the issue cycle
        drive(1'b1, ALUOP_R_TYP, FUNCT_MULT);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b1, ALUOP_R_TYP, FUNCT_MFLO);
        check("issue_flush_start", md_start, 0);
        check("issue_flush_stall", stall, 0);
        drive(1'b0, ALUOP_ZER_R, 6'h00);

        // MUL_CYCLES=1 instance
        d1_valid = 1'b1; d1_funct = FUNCT_MULT;
        tick();
        d1_funct = FUNCT_MFLO;
        #1;
        check("lat1_start", d1_md_start, 1);
        check("lat1_busy_stall", d1_stall, 1);
        check("lat1_busy_we", d1_hilo_we, 0);
        tick();
        check("lat1_done_we", d1_hilo_we, 1);
`ifdef HILO_FWD_EN
        check("lat1_done_stall", d1_stall, 0);
`else
        check("lat1_done_stall", d1_stall, 1);
`endif
        tick();
        check("lat1_idle_we", d1_hilo_we, 0);
        check("lat1_idle_stall", d1_stall, 0);
        d1_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
